// File: rtl/uart_pkg.sv
// uart_pkg: shared encodings for the parametrised UART receiver and its FIFO.
package uart_pkg;
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2, S_PUSH, S_WAIT_IDLE
  } state_e;
  typedef enum logic [1:0] {DB5, DB6, DB7, DB8} data_bits_e;
  typedef enum logic [1:0] {PAR_NONE, PAR_EVEN, PAR_ODD, PAR_NONE2} parity_e;
  localparam int ERR_FRAME  = 0;
  localparam int ERR_PARITY = 1;
  localparam int ERR_BREAK  = 2;
  function automatic logic [2:0] last_bit(input data_bits_e db);
    return {1'b0, db} + 3'd4;
  endfunction
endpackage

// File: rtl/uart_fifo_p.sv
// uart_fifo_p: first-word-fall-through synchronous FIFO with occupancy count.
module uart_fifo_p #(
  parameter int W     = 11,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [W-1:0]             wdata,
  input  logic                     pop,
  output logic [W-1:0]             rdata,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          wr, rd;
  assign full  = cnt_q == (AW+1)'(DEPTH);
  assign empty = cnt_q == '0;
  assign count = cnt_q;
  assign rdata = empty ? '0 : mem_q[rptr_q];
  // a pop frees the slot the same cycle, so a full FIFO still accepts push+pop
  always_comb begin
    wr     = push & (~full | pop);
    rd     = pop & ~empty;
    wptr_d = wptr_q + AW'(wr);
    rptr_d = rptr_q + AW'(rd);
    cnt_d  = cnt_q + (AW+1)'(wr) - (AW+1)'(rd);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end
  always_ff @(posedge clk)
    if (wr && !reset) mem_q[wptr_q] <= wdata;
endmodule

// File: rtl/uart_rx_p.sv
// uart_rx_p: run-time configurable UART receiver with majority-vote sampling and an error-tagged RX FIFO.
module uart_rx_p
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int BAUD_W     = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          rx,
  input  logic [BAUD_W-1:0]             baudrate,
  input  logic [1:0]                    cfg_data_bits,
  input  logic [1:0]                    cfg_parity,
  input  logic                          cfg_stop2,
  input  logic                          rx_pop,
  output logic [7:0]                    rx_data,
  output logic [2:0]                    rx_err,
  output logic                          rx_empty,
  output logic                          rx_full,
  output logic [$clog2(FIFO_DEPTH):0]   rx_count,
  output logic                          rx_overrun,
  input  logic                          clr_overrun
);
  localparam logic [BAUD_W-1:0] ONE = 1;
  state_e            state_q, state_d;
  data_bits_e        db_q, db_d;
  parity_e           par_q, par_d;
  logic              s1_q, s2_q;
  logic [2:0]        h_q;
  logic [BAUD_W-1:0] baud_q, baud_d, timer_q, timer_d;
  logic [2:0]        bitcnt_q, bitcnt_d;
  logic [7:0]        data_q, data_d;
  logic              st2_q, st2_d, perr_q, perr_d, ferr_q, ferr_d;
  logic              ones_q, ones_d, ovr_q, ovr_d;
  logic              maj, fall, tick, par_en, sampling, push;
  assign maj      = (h_q[0] & h_q[1]) | (h_q[0] & h_q[2]) | (h_q[1] & h_q[2]);
  assign fall     = h_q[1] & ~s2_q;
  assign tick     = timer_q == '0;
  assign par_en   = par_q == PAR_EVEN || par_q == PAR_ODD;
  assign sampling = state_q != S_IDLE && state_q != S_PUSH && state_q != S_WAIT_IDLE;
  assign rx_overrun = ovr_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      s1_q     <= 1'b1;
      s2_q     <= 1'b1;
      h_q      <= 3'b111;
      baud_q   <= '0;
      timer_q  <= '0;
      db_q     <= DB5;
      par_q    <= PAR_NONE;
      st2_q    <= 1'b0;
      bitcnt_q <= '0;
      data_q   <= '0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
      ones_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      s1_q     <= rx;
      s2_q     <= s1_q;
      h_q      <= {h_q[1:0], s2_q};
      baud_q   <= baud_d;
      timer_q  <= timer_d;
      db_q     <= db_d;
      par_q    <= par_d;
      st2_q    <= st2_d;
      bitcnt_q <= bitcnt_d;
      data_q   <= data_d;
      perr_q   <= perr_d;
      ferr_q   <= ferr_d;
      ones_q   <= ones_d;
      ovr_q    <= ovr_d;
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   state_d = fall ? S_START : S_IDLE;
      S_START:  if (tick) state_d = maj ? S_IDLE : S_DATA;
      S_DATA:   if (tick && bitcnt_q == last_bit(db_q)) state_d = par_en ? S_PARITY : S_STOP1;
      S_PARITY: if (tick) state_d = S_STOP1;
      S_STOP1:  if (tick) state_d = st2_q ? S_STOP2 : S_PUSH;
      S_STOP2:  if (tick) state_d = S_PUSH;
      S_PUSH:   state_d = ferr_q ? S_WAIT_IDLE : S_IDLE;
      default:  state_d = maj ? S_IDLE : S_WAIT_IDLE;
    endcase
  end
  // ones_q records any 1 among data, parity and first stop; its absence marks a break
  always_comb begin
    baud_d   = baud_q;
    timer_d  = timer_q;
    db_d     = db_q;
    par_d    = par_q;
    st2_d    = st2_q;
    bitcnt_d = bitcnt_q;
    data_d   = data_q;
    perr_d   = perr_q;
    ferr_d   = ferr_q;
    ones_d   = ones_q;
    if (state_q == S_IDLE && fall) begin
      baud_d   = baudrate;
      timer_d  = (baudrate >> 1) - ONE;
      db_d     = data_bits_e'(cfg_data_bits);
      par_d    = parity_e'(cfg_parity);
      st2_d    = cfg_stop2;
      bitcnt_d = '0;
      data_d   = '0;
      perr_d   = 1'b0;
      ferr_d   = 1'b0;
      ones_d   = 1'b0;
    end else if (sampling) begin
      timer_d = tick ? baud_q - ONE : timer_q - ONE;
      if (tick) begin
        ones_d = ones_q | (maj & (state_q == S_DATA || state_q == S_PARITY || state_q == S_STOP1));
        if (state_q == S_DATA) begin
          data_d[bitcnt_q] = maj;
          bitcnt_d         = bitcnt_q + 3'd1;
        end
        if (state_q == S_PARITY) perr_d = (^data_q ^ maj) != (par_q == PAR_ODD);
        if (state_q == S_STOP1) ferr_d = ~maj;
        if (state_q == S_STOP2) ferr_d = ferr_q | ~maj;
      end
    end
  end
  always_comb begin
    push  = state_q == S_PUSH;
    ovr_d = (push & rx_full & ~rx_pop) | (ovr_q & ~clr_overrun);
  end
  uart_fifo_p #(.W(11), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata ({~ones_q, perr_q, ferr_q, data_q}),
    .pop   (rx_pop),
    .rdata ({rx_err, rx_data}),
    .empty (rx_empty),
    .full  (rx_full),
    .count (rx_count)
  );
endmodule

// File: tb/tb_uart_rx_p.sv
// tb_uart_rx_p: directed frame table plus hand sequences for break, glitch, FIFO overrun and reset.
module tb_uart_rx_p;
  logic        clk = 0, reset = 1, rx = 1, cfg_stop2 = 0, rx_pop = 0, clr_overrun = 0;
  logic [15:0] baudrate = 16;
  logic [1:0]  cfg_data_bits = 2'd3, cfg_parity = 2'd0;
  logic [7:0]  rx_data;
  logic [2:0]  rx_err;
  logic        rx_empty, rx_full, rx_overrun;
  logic [4:0]  rx_count;
  int nchk = 0, nerr = 0, lat = -1;

  typedef struct {
    logic [1:0] db, par;
    logic       st2;
    logic [7:0] data;
    logic       pb, s1, s2;
    logic [7:0] ed;
    logic [2:0] ee;
  } vec_t;
  vec_t tv[12];

  uart_rx_p #(.FIFO_DEPTH(16), .BAUD_W(16)) dut (
    .clk(clk), .reset(reset), .rx(rx), .baudrate(baudrate),
    .cfg_data_bits(cfg_data_bits), .cfg_parity(cfg_parity), .cfg_stop2(cfg_stop2),
    .rx_pop(rx_pop), .rx_data(rx_data), .rx_err(rx_err), .rx_empty(rx_empty),
    .rx_full(rx_full), .rx_count(rx_count), .rx_overrun(rx_overrun), .clr_overrun(clr_overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    nchk++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic vec_t mk(input logic [1:0] db, par, input logic st2, input logic [7:0] d,
                              input logic pb, s1, s2, input logic [7:0] ed, input logic [2:0] ee);
    vec_t v;
    v.db = db; v.par = par; v.st2 = st2; v.data = d; v.pb = pb; v.s1 = s1; v.s2 = s2;
    v.ed = ed; v.ee = ee;
    return v;
  endfunction

  // configuration is scrambled after the start edge to prove it was latched
  task automatic send(input vec_t v, input int gbit, input int popc, input bit meas);
    logic b[$];
    baudrate = 16; cfg_data_bits = v.db; cfg_parity = v.par; cfg_stop2 = v.st2;
    b.push_back(1'b0);
    for (int i = 0; i < int'(v.db) + 5; i++) b.push_back(v.data[i]);
    if (v.par == 2'd1 || v.par == 2'd2) b.push_back(v.pb);
    b.push_back(v.s1);
    if (v.st2) b.push_back(v.s2);
    for (int k = 0; k < b.size(); k++)
      for (int c = 0; c < 16; c++) begin
        if (meas && k == b.size() - 1 && lat < 0 && !rx_empty) lat = c;
        rx = (k == gbit && c == 7) ? ~b[k] : b[k];
        rx_pop = (k == b.size() - 1 && c == popc);
        if (k == 0 && c == 4) begin
          baudrate = 9; cfg_data_bits = ~v.db; cfg_parity = v.par ^ 2'd1; cfg_stop2 = ~v.st2;
        end
        @(negedge clk);
      end
    rx = 1; rx_pop = 0;
    cyc(32);
  endtask

  task automatic wait_entry(input string n);
    for (int i = 0; i < 200 && rx_empty; i++) cyc(1);
    if (rx_empty) chk({n, "_wait"}, rx_empty, 0);
  endtask

  task automatic pop1();
    rx_pop = 1; cyc(1); rx_pop = 0;
  endtask

  initial begin
    tv[0]  = mk(2'd3, 2'd0, 0, 8'h55, 0, 1, 1, 8'h55, 3'b000);
    tv[1]  = mk(2'd2, 2'd1, 0, 8'h41, 1, 1, 1, 8'h41, 3'b010);
    tv[2]  = mk(2'd2, 2'd1, 0, 8'h41, 0, 1, 1, 8'h41, 3'b000);
    tv[3]  = mk(2'd0, 2'd0, 1, 8'h1F, 0, 1, 0, 8'h1F, 3'b001);
    tv[4]  = mk(2'd3, 2'd2, 0, 8'hA5, 1, 1, 1, 8'hA5, 3'b000);
    tv[5]  = mk(2'd3, 2'd2, 0, 8'hA5, 0, 1, 1, 8'hA5, 3'b010);
    tv[6]  = mk(2'd1, 2'd0, 0, 8'h3F, 0, 0, 1, 8'h3F, 3'b001);
    tv[7]  = mk(2'd3, 2'd1, 0, 8'h00, 0, 0, 1, 8'h00, 3'b101);
    tv[8]  = mk(2'd3, 2'd1, 0, 8'h00, 1, 0, 1, 8'h00, 3'b011);
    tv[9]  = mk(2'd0, 2'd0, 0, 8'hFF, 0, 1, 1, 8'h1F, 3'b000);
    tv[10] = mk(2'd3, 2'd3, 0, 8'h3C, 0, 1, 1, 8'h3C, 3'b000);
    tv[11] = mk(2'd1, 2'd1, 1, 8'h2A, 1, 1, 1, 8'h2A, 3'b000);

    cyc(3); reset = 0; cyc(2);
    chk("rst_empty", rx_empty, 1);
    chk("rst_full", rx_full, 0);
    chk("rst_count", rx_count, 0);
    chk("rst_overrun", rx_overrun, 0);
    chk("rst_data", rx_data, 0);
    chk("rst_err", rx_err, 0);

    send(tv[0], -1, -1, 1);
    chk("stop_to_empty", lat >= 8 && lat <= 24, 1);
    wait_entry("lat");
    chk("lat_data", rx_data, 8'h55);
    pop1();

    for (int i = 0; i < 12; i++) begin
      send(tv[i], -1, -1, 0);
      wait_entry($sformatf("vec%0d", i));
      chk($sformatf("vec%0d_data", i), rx_data, tv[i].ed);
      chk($sformatf("vec%0d_err", i), rx_err, tv[i].ee);
      pop1();
      chk($sformatf("vec%0d_empty", i), rx_empty, 1);
    end

    baudrate = 16; cfg_data_bits = 2'd3; cfg_parity = 2'd0; cfg_stop2 = 0;
    rx = 0; cyc(320);
    chk("break_count", rx_count, 1);
    chk("break_data", rx_data, 8'h00);
    chk("break_err", rx_err, 3'b101);
    rx = 1; cyc(48);
    chk("break_count_after", rx_count, 1);
    pop1();

    rx = 0; cyc(3); rx = 1; cyc(48);
    chk("glitch_rejected", rx_empty, 1);
    send(mk(2'd3, 2'd0, 0, 8'hA5, 0, 1, 1, 8'hA5, 3'b000), 2, -1, 0);
    wait_entry("glitch");
    chk("glitch_data", rx_data, 8'hA5);
    chk("glitch_err", rx_err, 3'b000);
    pop1();

    for (int i = 0; i < 17; i++) send(mk(2'd3, 2'd0, 0, 8'h10 + 8'(i), 0, 1, 1, 0, 0), -1, -1, 0);
    chk("ovr_full", rx_full, 1);
    chk("ovr_count", rx_count, 16);
    chk("ovr_flag", rx_overrun, 1);
    chk("ovr_head", rx_data, 8'h10);
    clr_overrun = 1; cyc(1); clr_overrun = 0;
    chk("ovr_clear", rx_overrun, 0);
    send(mk(2'd3, 2'd0, 0, 8'h40, 0, 1, 1, 0, 0), -1, lat - 1, 0);
    chk("pushpop_count", rx_count, 16);
    chk("pushpop_overrun", rx_overrun, 0);
    chk("pushpop_head", rx_data, 8'h11);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("drain%0d", i), rx_data, i < 15 ? 8'h11 + 8'(i) : 8'h40);
      pop1();
    end
    chk("drain_empty", rx_empty, 1);

    send(mk(2'd3, 2'd0, 0, 8'h33, 0, 1, 1, 0, 0), -1, -1, 0);
    chk("pre_reset_count", rx_count, 1);
    baudrate = 16; cfg_data_bits = 2'd3; cfg_parity = 2'd0; cfg_stop2 = 0;
    rx = 0; cyc(16); rx = 1; cyc(40);
    reset = 1; cyc(1); reset = 0;
    cyc(200);
    chk("midreset_empty", rx_empty, 1);
    chk("midreset_count", rx_count, 0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
